counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_if.sv | 13 +
 rtl/counter.sv | 45 ++++
 tb/tb_counter.sv | 115 +++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and the wrapped next-value function for the modulo counter.
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH = 8;

  // Sum is formed one bit wider than any legal count so value + step never overflows.
  function automatic logic [31:0] wrap_next(input logic [31:0] value,
                                            input logic [31:0] step,
                                            input logic [31:0] max_value);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, step};
    if (sum > {1'b0, max_value}) begin
      sum = sum - ({1'b0, max_value} + 33'd1);
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/counter_if.sv
// Bundles the counter output for consumers; the counter drives it through the source modport.
interface counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] value;

  modport source (output value);
  modport sink   (input  value);

endinterface

// File: rtl/counter.sv
// Modulo-(MAX_VALUE+1) counter advancing by STEP per clock, with synchronous active-low reset.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH       = COUNTER_DEFAULT_WIDTH,
  parameter longint unsigned  MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned  STEP        = 1,
  parameter longint unsigned  RESET_VALUE = 0
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter: WIDTH must be in 1..32");
  end
  if (MAX_VALUE == 0 || MAX_VALUE > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "counter: MAX_VALUE must satisfy 0 < MAX_VALUE <= 2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX_VALUE) begin : g_bad_step
    $fatal(1, "counter: STEP must satisfy 1 <= STEP <= MAX_VALUE");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $fatal(1, "counter: RESET_VALUE must not exceed MAX_VALUE");
  end

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = WIDTH'(wrap_next(32'(value_q), 32'(STEP), 32'(MAX_VALUE)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= WIDTH'(RESET_VALUE);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default, MAX_VALUE=9/STEP=4 and RESET_VALUE=5 instances on one reset.
module tb_counter;

  logic       clk;
  logic       reset;
  logic [3:0] val1;
  logic [7:0] val2;

  int unsigned checks;
  int unsigned errors;

  counter_if #(.WIDTH(8)) cnt_if ();

  counter u_dut0 (
    .value (cnt_if.value),
    .clk   (clk),
    .reset (reset)
  );

  counter #(.WIDTH(4), .MAX_VALUE(9), .STEP(4)) u_dut1 (
    .value (val1),
    .clk   (clk),
    .reset (reset)
  );

  counter #(.RESET_VALUE(5)) u_dut2 (
    .value (val2),
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] exp0;
  logic [3:0] seq1 [5];

  initial begin
    checks = 0;
    errors = 0;
    seq1   = '{4'd4, 4'd8, 4'd2, 4'd6, 4'd0};
    reset  = 1'b0;

    repeat (3) begin
      tick();
      check_eq("rst_hold", 32'(cnt_if.value), 32'h00);
    end
    check_eq("rst_step4", 32'(val1), 32'd0);
    check_eq("rst_rv5", 32'(val2), 32'd5);

    reset = 1'b1;
    exp0  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp0 = exp0 + 8'd1;
      check_eq("count", 32'(cnt_if.value), 32'(exp0));
      check_eq("step4_seq", 32'(val1), 32'(seq1[i]));
      if (i == 0) check_eq("rv5_next", 32'(val2), 32'd6);
    end

    // Full lap exercises the 0xFF -> 0x00 wrap.
    for (int i = 0; i < 256; i++) begin
      tick();
      exp0 = exp0 + 8'd1;
      if (exp0 == 8'h00) check_eq("wrap", 32'(cnt_if.value), 32'h00);
      else check_eq("lap", 32'(cnt_if.value), 32'(exp0));
    end

    while (exp0 != 8'h1c) begin
      tick();
      exp0 = exp0 + 8'd1;
      check_eq("to_1c", 32'(cnt_if.value), 32'(exp0));
    end

    reset = 1'b0;
    repeat (6) begin
      tick();
      check_eq("mid_rst", 32'(cnt_if.value), 32'h00);
      check_eq("mid_rst_rv5", 32'(val2), 32'd5);
    end
    reset = 1'b1;
    tick();
    exp0 = 8'h01;
    check_eq("rel_first", 32'(cnt_if.value), 32'h01);
    check_eq("rel_rv5", 32'(val2), 32'd6);

    // Pulse lives entirely between two rising edges and must be invisible.
    @(posedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    exp0 = exp0 + 8'd1;
    check_eq("glitch", 32'(cnt_if.value), 32'(exp0));
    tick();
    exp0 = exp0 + 8'd1;
    check_eq("glitch_after", 32'(cnt_if.value), 32'(exp0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
